// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the frontend branch predictor and its branch-queue
// producer port.
package branch_predictor_pkg;

    localparam int XLEN    = 32;
    localparam int ID_W    = 8;
    localparam int BQ_ID_W = 4;

    localparam int DEFAULT_NR_BHT_ENTRIES = 64;
    localparam int DEFAULT_NR_BTB_ENTRIES = 16;

    // Weakly not-taken
    localparam logic [1:0] BHT_CTR_INIT = 2'b01;

    typedef logic [XLEN-1:0]    xlen_t;
    typedef logic [ID_W-1:0]    id_t;
    typedef logic [BQ_ID_W-1:0] bq_id_t;

    typedef enum logic [2:0] {
        CTRL_JAL,
        CTRL_JALR,
        CTRL_BEQ,
        CTRL_BNE,
        CTRL_BLT,
        CTRL_BGE,
        CTRL_BLTU,
        CTRL_BGEU
    } ctrl_set_t;

    typedef struct packed {
        logic  taken;
        xlen_t pcnext;
    } bp_t;

    // Tag is kept full-width so the entry type does not depend on the table size.
    typedef struct packed {
        logic  valid;
        xlen_t tag;
        xlen_t target;
    } btb_entry_t;

    function automatic logic is_cond_branch(input ctrl_set_t op);
        return (op != CTRL_JAL) && (op != CTRL_JALR);
    endfunction

endpackage

// File: rtl/branch_predictor_ifs.sv
// Branch-queue push channel and pipeline squash channel.
interface bq_push_if;
    import branch_predictor_pkg::*;

    logic   valid;
    logic   ready;
    xlen_t  pc;
    id_t    id;
    bp_t    bp;
    bq_id_t bqid;

    modport master (output valid, pc, id, bp, input ready, bqid);
    modport slave  (input valid, pc, id, bp, output ready, bqid);
endinterface

interface squash_if;
    logic valid;

    modport master (output valid);
    modport slave  (input valid);
endinterface

// File: rtl/branch_predictor_bht.sv
// Bimodal branch history table: 2-bit saturating counters, one combinational read
// port and one training write port.
module bimodal_bht
    import branch_predictor_pkg::*;
#(
    parameter int NR_ENTRIES = DEFAULT_NR_BHT_ENTRIES
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [$clog2(NR_ENTRIES)-1:0] rd_idx,
    output logic [1:0]                    rd_ctr,
    input  logic                          wr_en,
    input  logic [$clog2(NR_ENTRIES)-1:0] wr_idx,
    input  logic                          wr_taken
);
    localparam int IDX_W = $clog2(NR_ENTRIES);

    logic [1:0] ctr_q [NR_ENTRIES];
    logic [1:0] wr_ctr_next;

    always_comb begin
        wr_ctr_next = ctr_q[wr_idx];
        if (wr_taken && (ctr_q[wr_idx] != 2'b11)) begin
            wr_ctr_next = ctr_q[wr_idx] + 2'b01;
        end else if (!wr_taken && (ctr_q[wr_idx] != 2'b00)) begin
            wr_ctr_next = ctr_q[wr_idx] - 2'b01;
        end
    end

    for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_ctr
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                ctr_q[gi] <= BHT_CTR_INIT;
            end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                ctr_q[gi] <= wr_ctr_next;
            end
        end
    end

    // Reads see the pre-update counter when training hits the same entry.
    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Frontend branch predictor: bimodal direction, direct-mapped JALR BTB, and a
// one-entry stage that pushes predictions into the branch queue.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int NR_BHT_ENTRIES = DEFAULT_NR_BHT_ENTRIES,
    parameter int NR_BTB_ENTRIES = DEFAULT_NR_BTB_ENTRIES
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  xlen_t           req_pc_i,
    input  id_t             req_id_i,
    input  xlen_t           req_imm_i,
    input  ctrl_set_t       req_op_i,
    output logic            resp_valid_o,
    output bp_t             resp_bp_o,
    output bq_id_t          resp_bqid_o,
    bq_push_if.master       bq_push_io,
    input  logic            train_valid_i,
    input  xlen_t           train_pc_i,
    input  ctrl_set_t       train_op_i,
    input  logic            train_taken_i,
    input  xlen_t           train_target_i,
    squash_if.slave         squash_io
);
    localparam int BHT_IDX_W = $clog2(NR_BHT_ENTRIES);
    localparam int BTB_IDX_W = $clog2(NR_BTB_ENTRIES);

    logic  stage_valid_q;
    xlen_t stage_pc_q;
    id_t   stage_id_q;
    bp_t   stage_bp_q;

    logic accept;
    logic push;
    bp_t  pred;

    logic [1:0]           bht_ctr;
    logic [BTB_IDX_W-1:0] btb_rd_idx;
    logic [BTB_IDX_W-1:0] btb_wr_idx;
    logic                 btb_we;
    logic                 btb_valid_q  [NR_BTB_ENTRIES];
    xlen_t                btb_tag_q    [NR_BTB_ENTRIES];
    xlen_t                btb_target_q [NR_BTB_ENTRIES];
    btb_entry_t           btb_rd;

    function automatic xlen_t btb_tag_of(input xlen_t pc);
        return pc >> (2 + BTB_IDX_W);
    endfunction

    // Squash blocks both the push and any new accept in the same cycle.
    assign push         = stage_valid_q && !squash_io.valid && bq_push_io.ready;
    assign req_ready_o  = !squash_io.valid && (!stage_valid_q || bq_push_io.ready);
    assign accept       = req_valid_i && req_ready_o;

    assign bq_push_io.valid = stage_valid_q && !squash_io.valid;
    assign bq_push_io.pc    = stage_pc_q;
    assign bq_push_io.id    = stage_id_q;
    assign bq_push_io.bp    = stage_bp_q;

    assign resp_valid_o = push;
    assign resp_bp_o    = push ? stage_bp_q : '0;
    assign resp_bqid_o  = push ? bq_push_io.bqid : '0;

    bimodal_bht #(
        .NR_ENTRIES (NR_BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .rstn     (rstn),
        .rd_idx   (req_pc_i[2 +: BHT_IDX_W]),
        .rd_ctr   (bht_ctr),
        .wr_en    (train_valid_i && is_cond_branch(train_op_i)),
        .wr_idx   (train_pc_i[2 +: BHT_IDX_W]),
        .wr_taken (train_taken_i)
    );

    assign btb_rd_idx = req_pc_i[2 +: BTB_IDX_W];
    assign btb_wr_idx = train_pc_i[2 +: BTB_IDX_W];
    assign btb_we     = train_valid_i && (train_op_i == CTRL_JALR);
    assign btb_rd     = '{valid:  btb_valid_q[btb_rd_idx],
                          tag:    btb_tag_q[btb_rd_idx],
                          target: btb_target_q[btb_rd_idx]};

    for (genvar gi = 0; gi < NR_BTB_ENTRIES; gi++) begin : g_btb
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                btb_valid_q[gi] <= 1'b0;
            end else if (btb_we && (btb_wr_idx == BTB_IDX_W'(gi))) begin
                btb_valid_q[gi] <= 1'b1;
            end
        end

        // Payload needs no reset: it is only consumed behind the valid bit.
        always_ff @(posedge clk) begin
            if (btb_we && (btb_wr_idx == BTB_IDX_W'(gi))) begin
                btb_tag_q[gi]    <= btb_tag_of(train_pc_i);
                btb_target_q[gi] <= train_target_i;
            end
        end
    end

    always_comb begin
        pred = '0;
        if (req_op_i == CTRL_JAL) begin
            pred.taken  = 1'b1;
            pred.pcnext = req_pc_i + req_imm_i;
        end else if (req_op_i == CTRL_JALR) begin
            // A BTB miss still predicts taken but falls through, forcing a redirect.
            pred.taken  = 1'b1;
            pred.pcnext = (btb_rd.valid && (btb_rd.tag == btb_tag_of(req_pc_i)))
                          ? btb_rd.target : req_pc_i + XLEN'(4);
        end else begin
            pred.taken  = bht_ctr[1];
            pred.pcnext = bht_ctr[1] ? req_pc_i + req_imm_i : req_pc_i + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_valid_q <= 1'b0;
            stage_pc_q    <= '0;
            stage_id_q    <= '0;
            stage_bp_q    <= '0;
        end else if (squash_io.valid) begin
            stage_valid_q <= 1'b0;
        end else if (accept) begin
            stage_valid_q <= 1'b1;
            stage_pc_q    <= req_pc_i;
            stage_id_q    <= req_id_i;
            stage_bp_q    <= pred;
        end else if (push) begin
            stage_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// table-level reference model of the predictor and a branch-queue stub.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int NBHT = DEFAULT_NR_BHT_ENTRIES;
    localparam int NBTB = DEFAULT_NR_BTB_ENTRIES;

    logic      clk;
    logic      rstn;
    logic      rv;
    logic      req_ready;
    xlen_t     rpc;
    id_t       rid;
    xlen_t     rimm;
    ctrl_set_t rop;
    logic      resp_valid;
    bp_t       resp_bp;
    bq_id_t    resp_bqid;
    logic      tv;
    xlen_t     tpc;
    ctrl_set_t top_op;
    logic      tt;
    xlen_t     ttgt;
    logic      sq;
    logic      bq_ready;
    bq_id_t    bq_alloc;

    bq_push_if bq_if ();
    squash_if  sq_if ();

    assign bq_if.ready = bq_ready;
    assign bq_if.bqid  = bq_alloc;
    assign sq_if.valid = sq;

    branch_predictor dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid_i    (rv),
        .req_ready_o    (req_ready),
        .req_pc_i       (rpc),
        .req_id_i       (rid),
        .req_imm_i      (rimm),
        .req_op_i       (rop),
        .resp_valid_o   (resp_valid),
        .resp_bp_o      (resp_bp),
        .resp_bqid_o    (resp_bqid),
        .bq_push_io     (bq_if),
        .train_valid_i  (tv),
        .train_pc_i     (tpc),
        .train_op_i     (top_op),
        .train_taken_i  (tt),
        .train_target_i (ttgt),
        .squash_io      (sq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model state
    typedef struct {
        xlen_t pc;
        id_t   id;
        bp_t   bp;
    } pend_t;

    int          bht_m     [NBHT];
    bit          btb_v_m   [NBTB];
    int unsigned btb_tag_m [NBTB];
    xlen_t       btb_tgt_m [NBTB];
    pend_t       pend [$];
    bp_t         push_bp_log [$];
    bq_id_t      push_bqid_log [$];

    int n_checks = 0;
    int n_fail   = 0;
    bit accepted = 0;
    id_t next_id = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NBHT; i++) bht_m[i] = 1;
        for (int i = 0; i < NBTB; i++) btb_v_m[i] = 0;
        pend.delete();
        bq_alloc = '0;
    endtask

    function automatic bp_t model_predict(input xlen_t pc, input xlen_t imm, input ctrl_set_t op);
        bp_t p;
        int unsigned bi = (pc / 4) % NBHT;
        int unsigned ti = (pc / 4) % NBTB;
        p.taken = 1'b1;
        case (op)
            CTRL_JAL:  p.pcnext = pc + imm;
            CTRL_JALR: p.pcnext = (btb_v_m[ti] && btb_tag_m[ti] == pc / (4 * NBTB))
                                  ? btb_tgt_m[ti] : pc + 4;
            default: begin
                p.taken  = (bht_m[bi] >= 2);
                p.pcnext = p.taken ? pc + imm : pc + 4;
            end
        endcase
        return p;
    endfunction

    task automatic model_train();
        int unsigned bi = (tpc / 4) % NBHT;
        int unsigned ti = (tpc / 4) % NBTB;
        if (top_op == CTRL_JALR) begin
            btb_v_m[ti]   = 1;
            btb_tag_m[ti] = tpc / (4 * NBTB);
            btb_tgt_m[ti] = ttgt;
        end else if (top_op != CTRL_JAL) begin
            if (tt) bht_m[bi] = (bht_m[bi] == 3) ? 3 : bht_m[bi] + 1;
            else    bht_m[bi] = (bht_m[bi] == 0) ? 0 : bht_m[bi] - 1;
        end
    endtask

    // One clock: inputs already driven after a negedge; check, advance model, cross posedge.
    task automatic step();
        bit    exp_ready;
        bit    exp_push;
        pend_t e;
        #1;
        exp_ready = !sq && (pend.size() == 0 || bq_ready);
        exp_push  = (pend.size() != 0) && !sq && bq_ready;
        check_val("req_ready", req_ready, exp_ready);
        check_val("resp_valid", resp_valid, exp_push);
        check_val("bq_valid", bq_if.valid, (pend.size() != 0) && !sq);
        if (pend.size() != 0 && !sq) begin
            check_val("bq_pc", bq_if.pc, pend[0].pc);
            check_val("bq_id", bq_if.id, pend[0].id);
            check_val("bq_bp", bq_if.bp, pend[0].bp);
        end
        accepted = 0;
        if (exp_push) begin
            e = pend.pop_front();
            check_val("resp_bp", resp_bp, e.bp);
            check_val("resp_bqid", resp_bqid, bq_alloc);
            push_bp_log.push_back(resp_bp);
            push_bqid_log.push_back(resp_bqid);
            $display("push bqid=%0d id=%0d pc=%08h taken=%0b pcnext=%08h",
                     resp_bqid, e.id, e.pc, resp_bp.taken, resp_bp.pcnext);
            bq_alloc = bq_alloc + 1'b1;
        end
        if (sq) begin
            pend.delete();
            bq_alloc = '0;
        end
        if (rv && exp_ready) begin
            pend.push_back('{pc: rpc, id: rid, bp: model_predict(rpc, rimm, rop)});
            accepted = 1;
        end
        if (tv) model_train();
        @(negedge clk);
    endtask

    task automatic send(input xlen_t pc, input xlen_t imm, input ctrl_set_t op);
        rv = 1'b1; rpc = pc; rimm = imm; rop = op; rid = next_id; next_id++;
        for (int k = 0; k < 20; k++) begin
            step();
            if (accepted) break;
        end
        if (!accepted) check_val("send_timeout", 0, 1);
        rv = 1'b0;
    endtask

    task automatic train(input xlen_t pc, input ctrl_set_t op, input logic taken, input xlen_t tgt);
        tv = 1'b1; tpc = pc; top_op = op; tt = taken; ttgt = tgt;
        step();
        tv = 1'b0;
    endtask

    task automatic check_last(input string tag, input logic taken, input xlen_t pcnext);
        if (push_bp_log.size() == 0) check_val(tag, 0, 1);
        else check_val(tag, push_bp_log[$], {taken, pcnext});
    endtask

    initial begin
        int n0;
        rv = 0; rpc = '0; rid = '0; rimm = '0; rop = CTRL_BEQ;
        tv = 0; tpc = '0; top_op = CTRL_BEQ; tt = 0; ttgt = '0;
        sq = 0; bq_ready = 1'b1;
        model_reset();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_resp_valid", resp_valid, 0);
        check_val("rst_bq_valid", bq_if.valid, 0);
        check_val("rst_resp_bp", resp_bp, 0);
        check_val("rst_resp_bqid", resp_bqid, 0);
        rstn = 1'b1;

        // Cold BEQ predicts not-taken
        send(32'h1000, 32'h40, CTRL_BEQ); step();
        check_last("beq_cold", 0, 32'h1004);
        check_val("beq_cold_bqid", push_bqid_log[$], 0);

        // Counter training and saturation at both ends
        repeat (2) train(32'h1000, CTRL_BEQ, 1, 0);
        send(32'h1000, 32'h40, CTRL_BEQ); step();
        check_last("beq_trained_t", 1, 32'h1040);
        repeat (2) train(32'h1000, CTRL_BEQ, 0, 0);
        send(32'h1000, 32'h40, CTRL_BEQ); step();
        check_last("beq_trained_nt", 0, 32'h1004);
        repeat (5) train(32'h1000, CTRL_BEQ, 1, 0);
        train(32'h1000, CTRL_BEQ, 0, 0);
        send(32'h1000, 32'h40, CTRL_BEQ); step();
        check_last("beq_sat_hi", 1, 32'h1040);
        repeat (5) train(32'h1000, CTRL_BEQ, 0, 0);
        train(32'h1000, CTRL_BEQ, 1, 0);
        send(32'h1000, 32'h40, CTRL_BEQ); step();
        check_last("beq_sat_lo", 0, 32'h1004);

        // JALR BTB miss, fill, hit, and alias miss
        send(32'h2000, 32'h100, CTRL_JALR); step();
        check_last("jalr_miss", 1, 32'h2004);
        train(32'h2000, CTRL_JALR, 1, 32'h8000);
        send(32'h2000, 32'h100, CTRL_JALR); step();
        check_last("jalr_hit", 1, 32'h8000);
        send(32'h2040, 32'h100, CTRL_JALR); step();
        check_last("jalr_alias", 1, 32'h2044);

        // BQ backpressure: one held in stage, one stalled at the request port
        bq_ready = 1'b0;
        n0 = push_bp_log.size();
        send(32'h1100, 32'h8, CTRL_JAL);
        rv = 1'b1; rpc = 32'h1200; rimm = 32'hFFFF_FFF0; rop = CTRL_JAL; rid = next_id; next_id++;
        repeat (5) step();
        check_val("stall_no_accept", accepted, 0);
        bq_ready = 1'b1;
        for (int k = 0; k < 5 && !accepted; k++) step();
        rv = 1'b0;
        step();
        check_val("stall_push_count", push_bp_log.size(), n0 + 2);
        if (push_bp_log.size() == n0 + 2) begin
            check_val("stall_bqid_seq", push_bqid_log[n0 + 1], push_bqid_log[n0] + 1'b1);
            check_val("stall_first_bp", push_bp_log[n0], {1'b1, 32'h1108});
            check_val("stall_second_bp", push_bp_log[n0 + 1], {1'b1, 32'h11F0});
        end

        // Squash drops the staged prediction; BQ restarts allocation at 0
        bq_ready = 1'b0;
        send(32'h1300, 32'h10, CTRL_JAL);
        n0 = push_bp_log.size();
        sq = 1'b1; bq_ready = 1'b1;
        step();
        sq = 1'b0;
        check_val("squash_no_push", push_bp_log.size(), n0);
        send(32'h1400, 32'h10, CTRL_JAL); step();
        check_val("post_squash_bqid", push_bqid_log[$], 0);

        // Asynchronous reset mid-operation clears the stage immediately
        bq_ready = 1'b0;
        send(32'h1500, 32'h10, CTRL_JAL);
        #2 rstn = 1'b0;
        #1 check_val("async_rst_bq_valid", bq_if.valid, 0);
        @(negedge clk);
        model_reset();
        rstn = 1'b1;
        bq_ready = 1'b1;

        // Same-cycle train and lookup: lookup sees the old counter
        rv = 1'b1; rpc = 32'h3000; rimm = 32'h20; rop = CTRL_BEQ; rid = next_id; next_id++;
        tv = 1'b1; tpc = 32'h3000; top_op = CTRL_BEQ; tt = 1'b1;
        step();
        tv = 1'b0; rid = next_id; next_id++;
        step();
        rv = 1'b0;
        step();
        check_val("same_cycle_old", push_bp_log[$-1], {1'b0, 32'h3004});
        check_val("same_cycle_new", push_bp_log[$], {1'b1, 32'h3020});

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            if (!rv || accepted) begin
                rv   = ($urandom_range(0, 3) != 0);
                rpc  = ($urandom_range(0, 7) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                                   : 32'h1000 + ($urandom_range(0, 127) << 2);
                rimm = $urandom();
                rop  = ctrl_set_t'(3'($urandom_range(0, 7)));
                rid  = next_id; next_id++;
            end
            tv     = ($urandom_range(0, 2) == 0);
            tpc    = 32'h1000 + ($urandom_range(0, 127) << 2);
            top_op = ctrl_set_t'(3'($urandom_range(0, 7)));
            tt     = 1'($urandom_range(0, 1));
            ttgt   = $urandom();
            sq     = ($urandom_range(0, 19) == 0);
            bq_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rv = 0; tv = 0; sq = 0; bq_ready = 1'b1;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
